pic_multi: RTL and testbench
============================

Name: pic_multi

Overview:
- Parametrised programmable interrupt controller and next-generation successor to the single 8-input edge-only PIC.
- Supports configurable channel count, per-input edge/level trigger mode, fixed or rotating priority, and automatic EOI.
- Sits on the data_m peripheral bus; drives the CPU intr/inta handshake with an 8-bit vector.
- No legacy ICW init sequence: all configuration is through directly addressed 16-bit registers.

Parameters:
- NUM_IRQ, 8, number of interrupt inputs; legal range 2..16.
- VECTOR_RESET, 8'h08, reset value of the vector base.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cs  input  1  block select
- data_m_addr  input  3  word register index
- data_m_data_in  input  16  write data
- data_m_data_out  output  16  read data; valid in the ack cycle, 0 otherwise
- data_m_bytesel  input  2  byte enables; bit0 = [7:0], bit1 = [15:8]
- data_m_wr_en  input  1  1 = write, 0 = read
- data_m_access  input  1  bus access strobe
- data_m_ack  output  1  access acknowledge
- intr_in  input  NUM_IRQ  interrupt request lines
- irq  output  8  vector presented with intr
- intr  output  1  interrupt request to the CPU
- inta  input  1  single-cycle interrupt acknowledge

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: data_m_data_out=0, data_m_ack=0, intr=0, irq=0. CTRL={VECTOR_RESET,5'b0,rotate=0,auto_eoi=0,enable=0}. MASK=all ones. MODE=0. IRR=0. ISR=0. last_serviced=NUM_IRQ-1. intr_last=0.
- Bus timing: data_m_ack <= cs&data_m_access. Read data registered with the same latency. Writes honour bytesel per byte. Unimplemented bits read 0. Addresses 6–7 read 0, writes ignored.
- Register map:
  - 0 CTRL: [0] enable, [1] auto_eoi, [2] rotate, [15:8] vector_base.
  - 1 MASK: 1 = masked.
  - 2 MODE: 1 = level, 0 = edge.
  - 3 IRR: read; writing 1 clears an edge-pending bit.
  - 4 ISR: read-only.
  - 5 EOI: write only; [8]=1 specific (clear ISR[[3:0]]; indices >= NUM_IRQ ignored); [8]=0 non-specific (clear the highest-priority set ISR bit).
- Input sampling: intr_last <= intr_in every cycle. edge[i] = intr_in[i] & ~intr_last[i].
- IRR, edge inputs: set on edge & ~mask; sticky until inta service or an IRR write-clear. A masked edge is dropped.
- IRR, level inputs: IRR[i] <= intr_in[i] & ~mask[i] each cycle; never sticky.
- Priority:
  - Fixed mode: index 0 highest.
  - Rotate mode: highest priority is (last_serviced+1) mod NUM_IRQ, wrapping.
- Winner and blocking: the winner is the highest-priority IRR bit. It is blocked when any ISR bit of equal or higher priority is set. In rotate mode, any set ISR bit blocks.
- Output registration: intr <= enable & ~inta & winner_valid; irq <= vector_base + winner index (8-bit add, wraps) when winner_valid, else irq holds.
- Latency: an edge on intr_in at cycle N sets IRR at the N edge; intr is high after the N+1 edge.
- inta cycle:
  - Using the currently presented index: ISR[idx] set (skipped if auto_eoi); IRR[idx] cleared if the input is edge mode; last_serviced <= idx.
  - intr is 0 the following cycle, then is re-evaluated.
- Spurious inta (intr=0): no state change.
- Simultaneous events:
  - New edge on the same bit in the inta cycle: IRR remains set.
  - EOI clear and inta set of the same ISR bit: set wins.
  - IRR write-clear and new edge: edge wins.
- enable=0: intr held low; IRR/ISR continue to update.
- Reset mid-handshake: all state returns to reset values; a later inta with intr=0 is ignored.

Test Plan:
- Set CTRL=0x2001 and MASK=0. Pulse intr_in[3] (edge) -> intr high 2 cycles later, irq=0x23. Pulse inta -> ISR=0x08, IRR=0, intr low next cycle.
- With ISR[3] set, raise intr_in[5] -> intr stays 0. Write EOI non-specific -> ISR=0, then intr=1 with irq=0x25.
- Nesting: with ISR[3] set, raise intr_in[1] -> irq=0x21 is delivered and ISR becomes 0x0A.
- MODE[2]=1: hold intr_in[2] high and service with EOI -> it re-asserts. Drop the line before inta -> intr falls and IRR[2]=0.
- rotate=1 with NUM_IRQ=8: requests on 0 and 7 with last_serviced=0 -> 7 served first (irq=base+7), then 0. auto_eoi=1 -> ISR stays 0.
- Edge and inta clear on the same bit in the same cycle -> IRR stays set. Assert reset while intr=1 -> all outputs 0 and MASK=0x00FF next cycle.

Source files
------------

// File: rtl/pic_multi.sv
// pic_multi: parametrised programmable interrupt controller.
//
// Gathers NUM_IRQ interrupt request lines (each edge- or level-triggered),
// selects the highest-priority pending, unmasked request (fixed or rotating
// priority, with in-service blocking) and presents it to the CPU as
// intr + an 8-bit vector (vector_base + index). Configuration and status
// live in directly addressed 16-bit registers on the data_m bus.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cs, data_m_*      peripheral bus: 3-bit word address, 16-bit write/read
//                     data, 2 byte enables, wr_en, access strobe, ack
//   intr_in           interrupt request lines (NUM_IRQ wide)
//   irq               vector presented while intr is high
//   intr              interrupt request to the CPU
//   inta              single-cycle interrupt acknowledge from the CPU
//
// Handshakes:
//   Bus: an access is taken in every cycle where cs & data_m_access is high;
//   data_m_ack follows one cycle later and, for reads, data_m_data_out carries
//   the register value in that same cycle (0 in every other cycle). There is
//   no back-pressure: every access is accepted.
//   CPU: intr high means irq holds a valid vector. inta is honoured only when
//   it coincides with intr high; it services the vector currently presented
//   and forces intr low in the following cycle. inta while intr is low is
//   ignored.
//
// Register map (word index):
//   0 CTRL  [0] enable, [1] auto_eoi, [2] rotate, [15:8] vector_base
//   1 MASK  1 = masked
//   2 MODE  1 = level, 0 = edge
//   3 IRR   read; writing 1 clears an edge-pending bit
//   4 ISR   read only
//   5 EOI   write only; [8]=1 specific (index [3:0]), [8]=0 non-specific
//   6,7     read 0, writes ignored
module pic_multi #(
  parameter int         NUM_IRQ      = 8,
  parameter logic [7:0] VECTOR_RESET = 8'h08
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic [2:0]         data_m_addr,
  input  logic [15:0]        data_m_data_in,
  output logic [15:0]        data_m_data_out,
  input  logic [1:0]         data_m_bytesel,
  input  logic               data_m_wr_en,
  input  logic               data_m_access,
  output logic               data_m_ack,
  input  logic [NUM_IRQ-1:0] intr_in,
  output logic [7:0]         irq,
  output logic               intr,
  input  logic               inta
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_IRQ - 1);

  // Configuration
  logic               enable;
  logic               auto_eoi;
  logic               rotate;
  logic [7:0]         vector_base;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mode;

  // Interrupt state
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] isr;
  logic [NUM_IRQ-1:0] intr_last;
  logic [3:0]         last_serviced;
  logic [3:0]         irq_idx;       // index behind the presented vector

  // Bus decode
  logic        bus_acc;
  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] rd_data;
  logic        eoi_wr;
  logic        eoi_specific;
  logic [3:0]  eoi_sel;

  // Priority resolution
  logic [NUM_IRQ-1:0] edge_det;
  logic [3:0]         start_idx;
  logic               win_found;
  logic [3:0]         win_idx;
  logic               blocked;
  logic               winner_valid;
  logic               eoi_found;
  logic [3:0]         eoi_idx;
  logic               serve;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] isr_next;

  // Position k in the priority order starting at base, wrapping at NUM_IRQ.
  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NUM_IRQ) s = s - NUM_IRQ;
    return s;
  endfunction

  assign bus_acc      = cs & data_m_access;
  assign bus_wr       = bus_acc & data_m_wr_en;
  assign bus_rd       = bus_acc & ~data_m_wr_en;
  assign eoi_wr       = bus_wr & (data_m_addr == 3'd5) & (|data_m_bytesel);
  assign eoi_specific = data_m_bytesel[1] & data_m_data_in[8];
  assign eoi_sel      = data_m_bytesel[0] ? data_m_data_in[3:0] : 4'd0;
  assign edge_det     = intr_in & ~intr_last;
  assign serve        = inta & intr;

  always_comb begin
    rd_data = 16'h0000;
    case (data_m_addr)
      3'd0:    rd_data = {vector_base, 5'b00000, rotate, auto_eoi, enable};
      3'd1:    rd_data = 16'(mask);
      3'd2:    rd_data = 16'(mode);
      3'd3:    rd_data = 16'(irr);
      3'd4:    rd_data = 16'(isr);
      default: rd_data = 16'h0000;
    endcase
  end

  // In rotate mode the most recently serviced input becomes lowest priority.
  always_comb begin
    start_idx = 4'd0;
    if (rotate) begin
      if (last_serviced >= LAST_IDX) start_idx = 4'd0;
      else                           start_idx = last_serviced + 4'd1;
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    eoi_found = 1'b0;
    eoi_idx   = 4'd0;
    blocked   = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!win_found && irr[wrap_idx(int'(start_idx), k)]) begin
        win_found = 1'b1;
        win_idx   = 4'(wrap_idx(int'(start_idx), k));
      end
      if (!eoi_found && isr[wrap_idx(int'(start_idx), k)]) begin
        eoi_found = 1'b1;
        eoi_idx   = 4'(wrap_idx(int'(start_idx), k));
      end
    end
    // Fixed mode: in-service bits at the winner's index or below (higher
    // priority) block it. Rotate mode: any in-service bit blocks.
    for (int j = 0; j < NUM_IRQ; j++) begin
      if (isr[j] && (rotate || j <= int'(win_idx))) blocked = 1'b1;
    end
    winner_valid = win_found & ~blocked;
  end

  // IRR: level inputs follow the line; edge inputs are sticky. A new edge
  // overrides both the bus write-clear and the inta clear in the same cycle.
  always_comb begin
    irr_next = irr;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode[i]) begin
        irr_next[i] = intr_in[i] & ~mask[i];
      end else begin
        if (bus_wr && data_m_addr == 3'd3 && data_m_bytesel[i / 8] && data_m_data_in[i])
          irr_next[i] = 1'b0;
        if (serve && int'(irq_idx) == i)
          irr_next[i] = 1'b0;
        if (edge_det[i] && !mask[i])
          irr_next[i] = 1'b1;
      end
    end
  end

  // ISR: EOI clears first, then an inta set on the same bit wins.
  always_comb begin
    isr_next = isr;
    if (eoi_wr) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (eoi_specific) begin
          if (int'(eoi_sel) == i) isr_next[i] = 1'b0;
        end else if (eoi_found && int'(eoi_idx) == i) begin
          isr_next[i] = 1'b0;
        end
      end
    end
    if (serve && !auto_eoi) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (int'(irq_idx) == i) isr_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_m_data_out <= 16'h0000;
      data_m_ack      <= 1'b0;
      intr            <= 1'b0;
      irq             <= 8'h00;
      irq_idx         <= 4'd0;
      enable          <= 1'b0;
      auto_eoi        <= 1'b0;
      rotate          <= 1'b0;
      vector_base     <= VECTOR_RESET;
      mask            <= '1;
      mode            <= '0;
      irr             <= '0;
      isr             <= '0;
      intr_last       <= '0;
      last_serviced   <= LAST_IDX;
    end else begin
      data_m_ack      <= bus_acc;
      data_m_data_out <= bus_rd ? rd_data : 16'h0000;
      intr_last       <= intr_in;

      if (bus_wr && data_m_addr == 3'd0) begin
        if (data_m_bytesel[0]) begin
          enable   <= data_m_data_in[0];
          auto_eoi <= data_m_data_in[1];
          rotate   <= data_m_data_in[2];
        end
        if (data_m_bytesel[1]) vector_base <= data_m_data_in[15:8];
      end

      for (int i = 0; i < NUM_IRQ; i++) begin
        if (bus_wr && data_m_addr == 3'd1 && data_m_bytesel[i / 8])
          mask[i] <= data_m_data_in[i];
        if (bus_wr && data_m_addr == 3'd2 && data_m_bytesel[i / 8])
          mode[i] <= data_m_data_in[i];
      end

      irr <= irr_next;
      isr <= isr_next;
      if (serve) last_serviced <= irq_idx;

      // The acknowledge cycle always drops intr; the next cycle re-evaluates.
      intr <= enable & ~inta & winner_valid;
      if (winner_valid) begin
        irq     <= vector_base + {4'b0000, win_idx};
        irq_idx <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_pic_multi.sv
// Testbench for pic_multi (NUM_IRQ = 8, VECTOR_RESET = 8'h08).
// Directed stimulus; expected read data and expected interrupt vectors are
// queued by the driver and popped by a negedge monitor.
module tb_pic_multi;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic [2:0]    data_m_addr;
  logic [15:0]   data_m_data_in;
  logic [15:0]   data_m_data_out;
  logic [1:0]    data_m_bytesel;
  logic          data_m_wr_en;
  logic          data_m_access;
  logic          data_m_ack;
  logic [N-1:0]  intr_in;
  logic [7:0]    irq;
  logic          intr;
  logic          inta;

  pic_multi #(.NUM_IRQ(N), .VECTOR_RESET(8'h08)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .intr_in         (intr_in),
    .irq             (irq),
    .intr            (intr),
    .inta            (inta)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  irq_q[$];
  logic        acc_flag  = 1'b0;
  logic        rd_flag   = 1'b0;
  logic        intr_prev = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Track which cycles carried a bus access, from the bench's own stimulus.
  always @(posedge clk) begin
    acc_flag <= cs & data_m_access;
    rd_flag  <= cs & data_m_access & ~data_m_wr_en;
  end

  always @(negedge clk) begin
    if (acc_flag) begin
      check("ack", 16'(data_m_ack), 16'h0001);
      if (rd_flag) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL rd_unexpected: got %h with no expected value queued", data_m_data_out);
        end else begin
          check(name_q.pop_front(), data_m_data_out, exp_q.pop_front());
        end
      end
    end else if (data_m_ack) begin
      n_total++;
      n_bad++;
      $display("FAIL ack_spurious: got ack=1 expected 0");
    end
    if (intr && !intr_prev) begin
      if (irq_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL irq_unexpected: got intr=1 irq=%h expected no interrupt", irq);
      end else begin
        check("irq_vector", 16'(irq), 16'(irq_q.pop_front()));
      end
    end
    intr_prev <= intr;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    tick();
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
    data_m_addr = a; data_m_data_in = d; data_m_bytesel = be;
    tick();
    cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_data_in = 16'h0000; data_m_bytesel = 2'b00;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
    data_m_addr = a; data_m_bytesel = 2'b11;
    tick();
    cs = 1'b0; data_m_access = 1'b0; data_m_bytesel = 2'b00;
  endtask

  task automatic pulse(input int i);
    tick();
    intr_in[i] = 1'b1;
    tick();
    intr_in[i] = 1'b0;
  endtask

  task automatic do_inta();
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic wait_intr(input string name);
    for (int i = 0; i < 50 && !intr; i++) tick();
    n_total++;
    if (!intr) begin
      n_bad++;
      $display("FAIL %s: got intr=0 after 50 cycles expected 1", name);
    end
  endtask

  task automatic eoi_nonspecific();
    bus_write(3'd5, 16'h0000, 2'b11);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; cs = 1'b0; data_m_addr = 3'd0; data_m_data_in = 16'h0000;
    data_m_bytesel = 2'b00; data_m_wr_en = 1'b0; data_m_access = 1'b0;
    intr_in = '0; inta = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_intr", 16'(intr), 16'h0000);
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_ack", 16'(data_m_ack), 16'h0000);
    check("rst_dout", data_m_data_out, 16'h0000);
    bus_read(3'd0, 16'h0800, "rst_ctrl");
    bus_read(3'd1, 16'h00FF, "rst_mask");
    bus_read(3'd2, 16'h0000, "rst_mode");
    bus_read(3'd3, 16'h0000, "rst_irr");
    bus_read(3'd4, 16'h0000, "rst_isr");
    bus_write(3'd6, 16'hFFFF, 2'b11);
    bus_read(3'd6, 16'h0000, "addr6");

    // Masked edge is dropped; disabled controller still latches IRR
    pulse(1);
    bus_read(3'd3, 16'h0000, "masked_edge");
    bus_write(3'd1, 16'h0000, 2'b11);
    bus_write(3'd0, 16'h2000, 2'b11);
    pulse(6);
    repeat (3) tick();
    check("disabled_intr", 16'(intr), 16'h0000);
    bus_read(3'd3, 16'h0040, "irr_disabled");
    bus_write(3'd3, 16'h0040, 2'b11);
    bus_read(3'd3, 16'h0000, "irr_wclear");
    bus_write(3'd0, 16'h3000, 2'b10);
    bus_read(3'd0, 16'h3000, "ctrl_bytesel");

    // Basic edge delivery and latency
    bus_write(3'd0, 16'h2001, 2'b11);
    irq_q.push_back(8'h23);
    pulse(3);
    check("lat_n1", 16'(intr), 16'h0000);
    tick();
    check("lat_n2", 16'(intr), 16'h0001);
    bus_read(3'd3, 16'h0008, "irr_pend3");
    do_inta();
    check("inta_drop", 16'(intr), 16'h0000);
    bus_read(3'd4, 16'h0008, "isr_3");
    bus_read(3'd3, 16'h0000, "irr_served3");

    // Lower priority blocked by in-service, released by non-specific EOI
    pulse(5);
    repeat (4) tick();
    check("blocked5", 16'(intr), 16'h0000);
    irq_q.push_back(8'h25);
    eoi_nonspecific();
    wait_intr("wait5");
    bus_read(3'd4, 16'h0000, "isr_after_eoi");
    do_inta();
    eoi_nonspecific();
    bus_read(3'd4, 16'h0000, "isr_clear5");

    // Nesting: higher priority interrupts an in-service lower one
    irq_q.push_back(8'h23);
    pulse(3);
    wait_intr("wait3");
    do_inta();
    irq_q.push_back(8'h21);
    pulse(1);
    wait_intr("wait1");
    do_inta();
    bus_read(3'd4, 16'h000A, "isr_nest");
    eoi_nonspecific();
    bus_read(3'd4, 16'h0008, "isr_nonspec");
    bus_write(3'd5, 16'h010B, 2'b11);
    bus_read(3'd4, 16'h0008, "eoi_out_of_range");
    bus_write(3'd5, 16'h0103, 2'b11);
    bus_read(3'd4, 16'h0000, "eoi_specific");

    // Level mode on input 2
    bus_write(3'd2, 16'h0004, 2'b11);
    irq_q.push_back(8'h22);
    tick();
    intr_in[2] = 1'b1;
    wait_intr("wait_lvl");
    do_inta();
    repeat (3) tick();
    check("level_blocked", 16'(intr), 16'h0000);
    bus_read(3'd3, 16'h0004, "irr_level");
    irq_q.push_back(8'h22);
    eoi_nonspecific();
    wait_intr("wait_lvl_again");
    tick();
    intr_in[2] = 1'b0;
    repeat (3) tick();
    check("level_drop", 16'(intr), 16'h0000);
    bus_read(3'd3, 16'h0000, "irr_level_drop");
    bus_write(3'd2, 16'h0000, 2'b11);

    // Rotating priority with auto EOI, last_serviced = 0
    irq_q.push_back(8'h20);
    pulse(0);
    wait_intr("wait0");
    do_inta();
    eoi_nonspecific();
    bus_read(3'd4, 16'h0000, "isr_pre_rot");
    bus_write(3'd0, 16'h2007, 2'b11);
    irq_q.push_back(8'h27);
    irq_q.push_back(8'h20);
    tick();
    intr_in[0] = 1'b1;
    intr_in[7] = 1'b1;
    tick();
    intr_in[0] = 1'b0;
    intr_in[7] = 1'b0;
    wait_intr("wait_rot7");
    do_inta();
    wait_intr("wait_rot0");
    bus_read(3'd4, 16'h0000, "isr_auto_eoi");
    do_inta();
    bus_read(3'd4, 16'h0000, "isr_auto_eoi2");
    bus_read(3'd3, 16'h0000, "irr_rot_done");

    // New edge in the same cycle as inta on that bit keeps IRR set
    bus_write(3'd0, 16'h2001, 2'b11);
    irq_q.push_back(8'h24);
    pulse(4);
    wait_intr("wait4");
    tick();
    intr_in[4] = 1'b1;
    inta = 1'b1;
    tick();
    intr_in[4] = 1'b0;
    inta = 1'b0;
    bus_read(3'd3, 16'h0010, "irr_edge_vs_inta");
    bus_read(3'd4, 16'h0010, "isr_edge_vs_inta");
    irq_q.push_back(8'h24);
    eoi_nonspecific();
    wait_intr("wait4_again");

    // Reset while intr is high
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_intr", 16'(intr), 16'h0000);
    check("rst2_irq", 16'(irq), 16'h0000);
    check("rst2_ack", 16'(data_m_ack), 16'h0000);
    check("rst2_dout", data_m_data_out, 16'h0000);
    bus_read(3'd1, 16'h00FF, "rst2_mask");
    bus_read(3'd0, 16'h0800, "rst2_ctrl");
    bus_read(3'd3, 16'h0000, "rst2_irr");
    do_inta();
    check("spurious_inta", 16'(intr), 16'h0000);
    bus_read(3'd4, 16'h0000, "rst2_isr");

    repeat (4) tick();
    check("exp_q_empty", 16'(exp_q.size()), 16'h0000);
    check("irq_q_empty", 16'(irq_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog: the stimulus is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
